// File: rtl/q4_interp.sv
// q4_interp: linear interpolator, Q(4,0) stream in -> Q(4,4) stream out at 2^LOG2_L times the rate.
// Rev 1.0
`default_nettype none

module q4_interp #(
   parameter int LOG2_L = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready
);

   localparam int c_L  = 1 << LOG2_L;
   localparam int c_KW = (LOG2_L == 0) ? 1 : LOG2_L;
   localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_L - 1);
   localparam logic [c_KW-1:0] c_K_ONE  = c_KW'(1);

   // Bit 1 of the state doubles as out_valid, so the output is a plain flop.
   localparam logic [1:0] S_EMPTY = 2'b00;
   localparam logic [1:0] S_WAIT  = 2'b01;
   localparam logic [1:0] S_EMIT  = 2'b10;

   logic [1:0]      r_state;
   logic [3:0]      r_prev;
   logic [3:0]      r_cur;
   logic [8:0]      r_step;
   logic [7:0]      r_acc;
   logic [c_KW-1:0] r_k;

   logic [4:0]      w_diff;
   logic [8:0]      w_diff_ext;
   logic [8:0]      w_step;

   assign w_diff     = {in_data[3], in_data} - {r_prev[3], r_prev};
   assign w_diff_ext = {{4{w_diff[4]}}, w_diff};
   // (cur - prev) / L expressed in Q(.,4): exact because LOG2_L <= 4.
   assign w_step     = w_diff_ext << (4 - LOG2_L);

   assign in_ready  = ~r_state[1];
   assign out_valid = r_state[1];
   assign out_data  = r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
         r_prev  <= '0;
         r_cur   <= '0;
         r_step  <= '0;
         r_acc   <= '0;
         r_k     <= '0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (in_valid) begin
                  r_prev  <= in_data;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (in_valid) begin
                  r_step  <= w_step;
                  r_acc   <= {r_prev, 4'b0000};
                  r_k     <= '0;
                  r_cur   <= in_data;
                  r_state <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  // Intermediate values stay between prev and cur, so wrap-around never occurs.
                  r_acc <= 8'({r_acc[7], r_acc} + r_step);
                  r_k   <= r_k + c_K_ONE;
                  if (r_k == c_K_LAST) begin
                     r_prev  <= r_cur;
                     r_state <= S_WAIT;
                  end
               end
            end
            default: r_state <= S_EMPTY;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_q4_interp.sv
// tb_q4_interp: directed, table-driven bench for q4_interp (LOG2_L=2 and LOG2_L=0 builds).
// Rev 1.0
`default_nettype none

module tb_q4_interp;

   logic       clk;
   logic       rst_n;

   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   logic [3:0] in_data0;
   logic       in_valid0;
   logic       in_ready0;
   logic [7:0] out_data0;
   logic       out_valid0;
   logic       out_ready0;

   int n_vec;
   int n_err;

   q4_interp #(.LOG2_L(2)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   q4_interp #(.LOG2_L(0)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data0),
      .in_valid  (in_valid0),
      .in_ready  (in_ready0),
      .out_data  (out_data0),
      .out_valid (out_valid0),
      .out_ready (out_ready0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]      din;
      int              n;
      logic [3:0][7:0] exp;
   } vec_t;

   typedef struct {
      logic [3:0] din;
      logic       expv;
      logic [7:0] exp;
   } vec0_t;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [3:0] d);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("send_in_ready", {7'd0, in_ready}, 8'h01);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Expects a back-to-back burst starting now, then out_valid low.
   task automatic collect(input string name, input int n, input logic [3:0][7:0] exp);
      for (int j = 0; j < n; j++) begin
         chk({name, "_valid"}, {7'd0, out_valid}, 8'h01);
         chk({name, "_data"},  out_data, exp[j]);
         chk({name, "_in_ready"}, {7'd0, in_ready}, 8'h00);
         @(negedge clk);
      end
      chk({name, "_end_valid"}, {7'd0, out_valid}, 8'h00);
      chk({name, "_end_in_ready"}, {7'd0, in_ready}, 8'h01);
   endtask

   vec_t  tab[4];
   vec0_t tab0[3];

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      in_data    = 4'h0;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      in_data0   = 4'h0;
      in_valid0  = 1'b0;
      out_ready0 = 1'b1;

      tab[0] = '{din: 4'h2, n: 0, exp: '0};
      tab[1] = '{din: 4'h6, n: 4, exp: {8'h50, 8'h40, 8'h30, 8'h20}};
      tab[2] = '{din: 4'h8, n: 4, exp: {8'hB8, 8'hF0, 8'h28, 8'h60}};
      tab[3] = '{din: 4'h7, n: 4, exp: {8'h34, 8'hF8, 8'hBC, 8'h80}};

      tab0[0] = '{din: 4'h1, expv: 1'b0, exp: 8'h00};
      tab0[1] = '{din: 4'hF, expv: 1'b1, exp: 8'h10};
      tab0[2] = '{din: 4'h7, expv: 1'b1, exp: 8'hF0};

      repeat (3) @(negedge clk);
      chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
      chk("rst_out_data",  out_data, 8'h00);
      chk("rst_in_ready",  {7'd0, in_ready}, 8'h01);
      rst_n = 1'b1;
      @(negedge clk);

      // Prime, ramp up, negative step, half-steps.
      for (int v = 0; v < 4; v++) begin
         send(tab[v].din);
         if (tab[v].n == 0) begin
            chk("prime_out_valid", {7'd0, out_valid}, 8'h00);
            chk("prime_in_ready",  {7'd0, in_ready}, 8'h01);
         end else begin
            collect($sformatf("vec%0d", v), tab[v].n, tab[v].exp);
         end
      end

      // Backpressure at j=1 with a stray in_valid that must be ignored.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(4'h2);
      send(4'h6);
      chk("bp_j0", out_data, 8'h20);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'hF;
      for (int c = 0; c < 3; c++) begin
         chk("bp_hold_data",     out_data, 8'h30);
         chk("bp_hold_valid",    {7'd0, out_valid}, 8'h01);
         chk("bp_hold_in_ready", {7'd0, in_ready}, 8'h00);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      collect("bp_resume", 3, {8'h00, 8'h50, 8'h40, 8'h30});

      // Reset in the middle of a burst.
      send(4'h8);
      chk("mr_j0", out_data, 8'h60);
      @(negedge clk);
      chk("mr_j1", out_data, 8'h28);
      @(negedge clk);
      chk("mr_j2", out_data, 8'hF0);
      rst_n = 1'b0;
      #1;
      chk("mr_out_valid", {7'd0, out_valid}, 8'h00);
      chk("mr_out_data",  out_data, 8'h00);
      chk("mr_in_ready",  {7'd0, in_ready}, 8'h01);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(4'h3);
      chk("mr_reprime_valid", {7'd0, out_valid}, 8'h00);
      send(4'h3);
      collect("mr_flat", 4, {8'h30, 8'h30, 8'h30, 8'h30});

      // LOG2_L=0: pure format conversion with one-sample delay.
      for (int v = 0; v < 3; v++) begin
         in_valid0 = 1'b1;
         in_data0  = tab0[v].din;
         chk("l0_in_ready", {7'd0, in_ready0}, 8'h01);
         @(negedge clk);
         in_valid0 = 1'b0;
         chk("l0_out_valid", {7'd0, out_valid0}, {7'd0, tab0[v].expv});
         if (tab0[v].expv) chk("l0_out_data", out_data0, tab0[v].exp);
         @(negedge clk);
         chk("l0_after_valid", {7'd0, out_valid0}, 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/q4_interp.md
# q4_interp

Linear interpolator that expands a stream of Q(4,0) samples into a stream of Q(4,4) samples at L = 2^LOG2_L times the input rate. It performs the precision-expanding direction of the fixed-point datapath. Coarse 4-bit integer samples become 8-bit fractional samples by inserting L−1 exact, evenly spaced intermediate values between consecutive inputs. It sits between the Q(4,0) producer and any Q(4,4) consumer, with valid/ready handshakes on both sides.

## Interface
- LOG2_L, default 2, upsampling exponent; L = 2^LOG2_L; legal range 0..4 (step stays exact in 4 fractional bits)
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  4  signed two's-complement Q(4,0) sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a sample
- out_data  out  8  signed two's-complement Q(4,4) sample
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data

## Operation
- Input accepted on a rising edge with in_valid && in_ready; output beat transferred on a rising edge with out_valid && out_ready.
- Internal registers: prev (4b), step (signed, ≥9b), acc (8b), k (LOG2_L bits, min 1), state.
- FSM states:
  - EMPTY: no previous sample; in_ready=1, out_valid=0. On accept: prev ← in_data, go WAIT. No output is produced.
  - WAIT: prev held; in_ready=1, out_valid=0. On accept: step ← (in_data − prev) sign-extended, shifted left by (4 − LOG2_L); acc ← prev << 4; k ← 0; cur ← in_data; go EMIT.
  - EMIT: in_ready=0, out_valid=1, out_data=acc. On each transfer: acc ← acc + step, k ← k+1. On the transfer with k = L−1: prev ← cur, go WAIT.
- Each pair (prev, cur) produces the L values prev + j·(cur−prev)/L, j = 0..L−1. The value cur is emitted as j=0 of the next pair.
- Arithmetic: difference range −15..+15 (5b signed). All produced values lie between prev and cur, so the 8-bit result never overflows. No rounding and no saturation.
- LOG2_L = 0: each accepted sample after the first emits exactly prev<<4 once (pure format conversion, one-sample delay).
- The first sample after reset primes prev only. The stream output lags the input by one sample.

## Timing
- Reset (async assert, sync release): state=EMPTY, in_ready=1, out_valid=0, out_data=8'h00, prev=0, acc=0, k=0.
- Latency: a sample accepted in WAIT at edge t gives out_valid=1 with j=0 value from cycle after t.
- Outputs registered: out_data and out_valid change only on clock edges or reset.
- Backpressure: while out_valid && !out_ready, out_data, acc, k and state are held stable.
- in_ready is a function of state only; it does not depend on out_ready or in_valid.
- Max throughput: L output beats per L+1 cycles (one WAIT cycle per input).
- Reset asserted mid-EMIT: burst aborted immediately, prev discarded. After release, the next sample re-primes (EMPTY).
- in_valid asserted during EMIT is ignored (in_ready=0). The producer must hold the sample until accepted.

## Test plan
- Reset/prime (LOG2_L=2): after reset out_valid=0, out_data=0x00, in_ready=1. Send 0x2 → no output, in_ready stays 1.
- Ramp up: prime 0x2, send 0x6, out_ready=1 → out_data 0x20, 0x30, 0x40, 0x50 on consecutive cycles, then out_valid=0.
- Negative and half-steps: continue with 0x8 (−8) → 0x60, 0x28, 0xF0, 0xB8. Then send 0x7 → 0x80, 0xBC, 0xF8, 0x34.
- Backpressure: during the 0x6 burst drop out_ready for 3 cycles at j=1 → out_data held at 0x30, out_valid=1, in_ready=0. Sequence resumes unchanged.
- Reset mid-burst: assert rst_n=0 at j=2 → out_valid=0 and out_data=0x00 immediately. After release, 0x3 then 0x3 → 0x30 ×4.
- LOG2_L=0 build: inputs 0x1, 0xF, 0x7 → outputs 0x10, 0xF0, one beat per input after the first.
